// File: rtl/sram_march_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_march_ctrl_if
//
// Bus between the March C- BIST sequencer and the single-port SRAM under test.
//
//   bank  BANK_W  bank select toward the SRAM mux
//   cen   1       chip enable, active low
//   wen   1       write enable, active low, meaningful only while cen = 0
//   addr  ADDR_W  word address
//   din   DATA_W  write data
//   dout  DATA_W  read data, valid the cycle after a read access
//
// master : the BIST sequencer (drives everything except dout)
// slave  : the SRAM side (returns dout)
// ---------------------------------------------------------------------------
interface sram_march_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int BANK_W = 2
);
   logic [BANK_W-1:0] bank;
   logic              cen;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;

   modport master (output bank, output cen, output wen, output addr, output din, input dout);
   modport slave  (input bank, input cen, input wen, input addr, input din, output dout);
endinterface

// File: rtl/sram_march_ctrl.sv
// ---------------------------------------------------------------------------
// sram_march_ctrl
//
// March C- BIST sequencer for one synchronous single-port SRAM. Walks the six
// March C- elements, compares every read against the expected background and
// reports pass/fail, capturing address, element and data of the first miss.
//
//   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   start_i             one-cycle start request, honoured in IDLE or DONE
//   abort_i             synchronous abort, beats a simultaneous start
//   bank_i              bank to test, latched when a start is accepted
//   sram                master side of the SRAM bus (bank/cen/wen/addr/din/dout)
//   busy_o              sequence running
//   done_o              sticky completion flag, cleared by the next accepted start
//   pass_o              1 when the finished run saw no mismatch
//   fail_addr_o         address of the first mismatch
//   fail_elem_o         March element (0..5) of the first mismatch
//   fail_data_o         read data captured at the first mismatch
// ---------------------------------------------------------------------------
module sram_march_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int BANK_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [BANK_W-1:0] bank_i,
   sram_march_ctrl_if.master sram,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o,
   output logic [DATA_W-1:0] fail_data_o
);

   typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ADDR_W-1:0] failAddr_q, failAddr_d;
   logic [2:0]        failElem_q, failElem_d;
   logic [DATA_W-1:0] failData_q, failData_d;
   logic              busy_q, cen_q, wen_q;
   logic [DATA_W-1:0] din_q;

   logic              dirUp;
   logic              lastAddr;
   logic              nextElemDown;
   logic [DATA_W-1:0] rdExpect;
   logic [DATA_W-1:0] wrPattern;

   // Element decode. E3/E4 walk downwards, everything else upwards. Reads in
   // E2/E4 expect all-ones; writes in E1/E3 store all-ones. The write pattern
   // is taken from the element being entered so it lines up with the
   // registered din.
   always_comb begin
      dirUp        = !((elem_q == 3'd3) || (elem_q == 3'd4));
      lastAddr     = dirUp ? (addr_q == ADDR_MAX) : (addr_q == '0);
      nextElemDown = (elem_q == 3'd2) || (elem_q == 3'd3);
      rdExpect     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
      wrPattern    = ((elem_d == 3'd1) || (elem_d == 3'd3)) ? '1 : '0;
   end

   // Next-state logic. WR is the last operation of E0..E4 at each address, so
   // only WR advances the address or element there; E5 has no write and
   // advances from CMP instead. Rolling into a new element happens on the same
   // edge as the last operation of the old one, so element changes cost no
   // cycles. Abort overrides everything, including a start in the same cycle.
   always_comb begin
      state_d    = state_q;
      elem_d     = elem_q;
      addr_d     = addr_q;
      bank_d     = bank_q;
      done_d     = done_q;
      pass_d     = pass_q;
      failAddr_d = failAddr_q;
      failElem_d = failElem_q;
      failData_d = failData_q;
      if (abort_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_d    = WR;
                  bank_d     = bank_i;
                  done_d     = 1'b0;
                  pass_d     = 1'b0;
                  failAddr_d = '0;
                  failElem_d = '0;
                  failData_d = '0;
                  elem_d     = '0;
                  addr_d     = '0;
               end
            end
            WR: begin
               if (lastAddr) begin
                  elem_d  = elem_q + 3'd1;
                  addr_d  = nextElemDown ? ADDR_MAX : '0;
                  state_d = RD;
               end else begin
                  addr_d  = dirUp ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
                  state_d = (elem_q == 3'd0) ? WR : RD;
               end
            end
            RD: begin
               state_d = CMP;
            end
            CMP: begin
               if (sram.dout != rdExpect) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  pass_d     = 1'b0;
                  failAddr_d = addr_q;
                  failElem_d = elem_q;
                  failData_d = sram.dout;
               end else if (elem_q == 3'd5) begin
                  if (lastAddr) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     pass_d  = 1'b1;
                  end else begin
                     addr_d  = addr_q + ADDR_ONE;
                     state_d = RD;
                  end
               end else begin
                  state_d = WR;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State register. The SRAM strobes and busy are decoded from the state
   // being entered, so every output comes straight from a flop and reflects
   // the state the FSM is in during that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         elem_q     <= '0;
         addr_q     <= '0;
         bank_q     <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         failAddr_q <= '0;
         failElem_q <= '0;
         failData_q <= '0;
         busy_q     <= 1'b0;
         cen_q      <= 1'b1;
         wen_q      <= 1'b1;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         addr_q     <= addr_d;
         bank_q     <= bank_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         failAddr_q <= failAddr_d;
         failElem_q <= failElem_d;
         failData_q <= failData_d;
         busy_q     <= (state_d == WR) || (state_d == RD) || (state_d == CMP);
         cen_q      <= !((state_d == WR) || (state_d == RD));
         wen_q      <= (state_d != WR);
         din_q      <= (state_d == WR) ? wrPattern : '0;
      end
   end

   assign sram.bank   = bank_q;
   assign sram.cen    = cen_q;
   assign sram.wen    = wen_q;
   assign sram.addr   = addr_q;
   assign sram.din    = din_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign fail_addr_o = failAddr_q;
   assign fail_elem_o = failElem_q;
   assign fail_data_o = failData_q;

endmodule
